// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: rebuilds BCD digits from a scanned, active-low 7-segment bus.
// Define SEG7_HEX_DECODE_EN to also accept the hex letter patterns A-F.
module seg7_scan_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [7:0]              an,
  input  logic [6:0]              seg,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    frame_done,
  output logic                    err_pattern,
  output logic                    err_anode
);

  localparam int                    CW       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]         CNT_MAX  = CW'(STABLE_CYCLES);
  localparam logic [7:0]            ALLOWED  = 8'((1 << NUM_DIGITS) - 1);
  localparam logic [NUM_DIGITS-1:0] ALL_SEEN = '1;

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t                  state_q, state_d;
  logic [7:0]              an_q, lat_an_q, lat_an_d;
  logic [6:0]              seg_q, lat_seg_q, lat_seg_d;
  logic [CW-1:0]           count_q, count_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic                    frame_done_q, frame_done_d;
  logic                    err_pattern_q, err_pattern_d;
  logic                    err_anode_q, err_anode_d;
  logic                    bad_prev_q, bad_prev_d;

  logic [7:0] an_low;
  logic       any_low, one_low, bus_bad, bus_same, accept;
  logic       dec_ok;
  logic [3:0] dec_val;

  // A valid select is exactly one low anode inside the configured digit range.
  always_comb begin
    an_low   = ~an_q;
    any_low  = |an_low;
    one_low  = any_low && ((an_low & (an_low - 8'd1)) == 8'd0);
    bus_bad  = any_low && !(one_low && ((an_low & ~ALLOWED) == 8'd0));
    bus_same = (an_q == lat_an_q) && (seg_q == lat_seg_q);
  end

  always_comb begin
    dec_ok  = 1'b1;
    dec_val = 4'h0;
    case (lat_seg_q)
      7'b0000001: dec_val = 4'h0;
      7'b1001111: dec_val = 4'h1;
      7'b0010010: dec_val = 4'h2;
      7'b0000110: dec_val = 4'h3;
      7'b1001100: dec_val = 4'h4;
      7'b0100100: dec_val = 4'h5;
      7'b0100000: dec_val = 4'h6;
      7'b0001111: dec_val = 4'h7;
      7'b0000000: dec_val = 4'h8;
      7'b0000100: dec_val = 4'h9;
`ifdef SEG7_HEX_DECODE_EN
      7'b0001000: dec_val = 4'hA;
      7'b1100000: dec_val = 4'hB;
      7'b0110001: dec_val = 4'hC;
      7'b1000010: dec_val = 4'hD;
      7'b0110000: dec_val = 4'hE;
      7'b0111000: dec_val = 4'hF;
`endif
      default:    dec_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    lat_an_d      = lat_an_q;
    lat_seg_d     = lat_seg_q;
    digits_d      = digits_q;
    valid_d       = valid_q;
    seen_d        = seen_q;
    frame_done_d  = 1'b0;
    err_pattern_d = 1'b0;
    err_anode_d   = 1'b0;
    bad_prev_d    = bus_bad;
    accept        = 1'b0;

    if (!enable) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      if (seen_q == ALL_SEEN) begin
        frame_done_d = 1'b1;
        seen_d       = '0;
      end
      if (bus_bad) begin
        err_anode_d = !bad_prev_q;
        state_d     = IDLE;
        count_d     = '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (any_low) begin
              state_d   = SETTLE;
              count_d   = CW'(1);
              lat_an_d  = an_q;
              lat_seg_d = seg_q;
            end
          end
          SETTLE: begin
            if (!any_low) begin
              state_d = IDLE;
              count_d = '0;
            end else if (bus_same) begin
              if (count_q >= CNT_MAX - CW'(1)) begin
                accept  = 1'b1;
                state_d = HOLD;
                count_d = CNT_MAX;
              end else begin
                count_d = count_q + CW'(1);
              end
            end else begin
              count_d   = CW'(1);
              lat_an_d  = an_q;
              lat_seg_d = seg_q;
            end
          end
          HOLD: begin
            if (!any_low) begin
              state_d = IDLE;
              count_d = '0;
            end else if (!bus_same) begin
              state_d   = SETTLE;
              count_d   = CW'(1);
              lat_an_d  = an_q;
              lat_seg_d = seg_q;
            end
          end
          default: begin
            state_d = IDLE;
            count_d = '0;
          end
        endcase
      end

      // The seen bit of a digit accepted on the frame edge survives the clear.
      if (accept) begin
        if (dec_ok) begin
          for (int k = 0; k < NUM_DIGITS; k++) begin
            if (!lat_an_q[k]) begin
              digits_d[4*k +: 4] = dec_val;
              valid_d[k]         = 1'b1;
              seen_d[k]          = 1'b1;
            end
          end
        end else begin
          err_pattern_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      an_q          <= '1;
      seg_q         <= '1;
      state_q       <= IDLE;
      count_q       <= '0;
      lat_an_q      <= '1;
      lat_seg_q     <= '1;
      digits_q      <= '0;
      valid_q       <= '0;
      seen_q        <= '0;
      frame_done_q  <= 1'b0;
      err_pattern_q <= 1'b0;
      err_anode_q   <= 1'b0;
      bad_prev_q    <= 1'b0;
    end else begin
      an_q          <= an;
      seg_q         <= seg;
      state_q       <= state_d;
      count_q       <= count_d;
      lat_an_q      <= lat_an_d;
      lat_seg_q     <= lat_seg_d;
      digits_q      <= digits_d;
      valid_q       <= valid_d;
      seen_q        <= seen_d;
      frame_done_q  <= frame_done_d;
      err_pattern_q <= err_pattern_d;
      err_anode_q   <= err_anode_d;
      bad_prev_q    <= bad_prev_d;
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign frame_done  = frame_done_q;
  assign err_pattern = err_pattern_q;
  assign err_anode   = err_anode_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Self-checking bench for seg7_scan_capture: directed scenarios plus random bus traffic,
// compared every cycle against a run-length reference model of the scanned bus.
module tb_seg7_scan_capture;

  localparam int ND = 4;
  localparam int SC = 16;

  logic        clk_in = 1'b0;
  logic        reset  = 1'b1;
  logic        enable = 1'b1;
  logic [7:0]  an     = 8'hFF;
  logic [6:0]  seg    = 7'h7F;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic        frame_done, err_pattern, err_anode;

  seg7_scan_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .enable      (enable),
    .an          (an),
    .seg         (seg),
    .digits      (digits),
    .digit_valid (digit_valid),
    .frame_done  (frame_done),
    .err_pattern (err_pattern),
    .err_anode   (err_anode)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: registered bus copy, length of the current run of identical samples.
  logic [6:0]  pat_tab [16];
  int          n_tab;
  logic [7:0]  m_an;
  logic [6:0]  m_seg;
  logic [14:0] m_last;
  int          m_run;
  bit          m_prev_bad;
  logic [15:0] m_digits;
  logic [3:0]  m_valid, m_seen;
  logic        m_fd, m_ep, m_ea;
  int          p_fd, p_ep, p_ea;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int count_low(input logic [7:0] a, output int pos);
    int n = 0;
    pos = 0;
    for (int i = 0; i < 8; i++)
      if (a[i] == 1'b0) begin
        n++;
        pos = i;
      end
    return n;
  endfunction

  function automatic bit lookup(input logic [6:0] p, output logic [3:0] v);
    v = 4'h0;
    for (int i = 0; i < n_tab; i++)
      if (pat_tab[i] == p) begin
        v = 4'(i);
        return 1'b1;
      end
    return 1'b0;
  endfunction

  task automatic model_edge(input logic [7:0] a, input logic [6:0] s, input logic en, input logic rst);
    int nl, pos;
    bit bad;
    logic [3:0] v;
    if (rst) begin
      m_an = 8'hFF; m_seg = 7'h7F; m_last = '1; m_run = 0; m_prev_bad = 0;
      m_digits = '0; m_valid = '0; m_seen = '0; m_fd = 0; m_ep = 0; m_ea = 0;
      return;
    end
    m_fd = 0; m_ep = 0; m_ea = 0;
    nl  = count_low(m_an, pos);
    bad = (nl > 1) || (nl == 1 && pos >= ND);
    if (!en) begin
      m_run = 0;
    end else begin
      if (m_run > 0 && {m_an, m_seg} == m_last) m_run++;
      else m_run = 1;
      m_last = {m_an, m_seg};
      if (m_seen == 4'hF) begin
        m_fd   = 1;
        m_seen = '0;
      end
      m_ea = bad && !m_prev_bad;
      if (m_run == SC && nl == 1 && pos < ND) begin
        if (lookup(m_seg, v)) begin
          m_digits[4*pos +: 4] = v;
          m_valid[pos] = 1'b1;
          m_seen[pos]  = 1'b1;
        end else begin
          m_ep = 1;
        end
      end
    end
    m_prev_bad = bad;
    m_an  = a;
    m_seg = s;
  endtask

  task automatic tick(input logic [7:0] a, input logic [6:0] s, input logic en, input logic rst);
    an = a; seg = s; enable = en; reset = rst;
    @(posedge clk_in);
    model_edge(a, s, en, rst);
    #1;
    check("digits", 32'(digits), 32'(m_digits));
    check("digit_valid", 32'(digit_valid), 32'(m_valid));
    check("frame_done", 32'(frame_done), 32'(m_fd));
    check("err_pattern", 32'(err_pattern), 32'(m_ep));
    check("err_anode", 32'(err_anode), 32'(m_ea));
    p_fd += int'(frame_done);
    p_ep += int'(err_pattern);
    p_ea += int'(err_anode);
  endtask

  task automatic hold(input int n, input logic [7:0] a, input logic [6:0] s);
    for (int i = 0; i < n; i++) tick(a, s, 1'b1, 1'b0);
  endtask

  initial begin
    logic [7:0] ra;
    int kind, hl, b1, b2;
    pat_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100,
                7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
`ifdef SEG7_HEX_DECODE_EN
    n_tab = 16;
`else
    n_tab = 10;
`endif
    model_edge(8'hFF, 7'h7F, 1'b1, 1'b1);

    tick(8'hFF, 7'h7F, 1'b1, 1'b1);
    tick(8'hFF, 7'h7F, 1'b1, 1'b1);
    check("reset_digits", 32'(digits), 32'h0);
    check("reset_valid", 32'(digit_valid), 32'h0);

    $display("[TB] single digit capture");
    hold(16, 8'hFE, pat_tab[3]);
    check("t1_valid_before_accept", 32'(digit_valid), 32'h0);
    hold(1, 8'hFE, pat_tab[3]);
    check("t1_digit0", 32'(digits[3:0]), 32'h3);
    check("t1_valid", 32'(digit_valid), 32'h1);
    hold(3, 8'hFE, pat_tab[3]);

    $display("[TB] full frame scan");
    p_fd = 0; p_ep = 0; p_ea = 0;
    for (int d = 0; d < 4; d++) hold(20, ~(8'h01 << d), pat_tab[d+1]);
    check("t2_digits", 32'(digits), 32'h4321);
    check("t2_valid", 32'(digit_valid), 32'hF);
    check("t2_frame_pulses", 32'(p_fd), 32'd1);

    $display("[TB] glitching segments");
    p_fd = 0; p_ep = 0; p_ea = 0;
    for (int r = 0; r < 4; r++) begin
      hold(9, 8'hFE, pat_tab[7]);
      hold(1, 8'hFE, pat_tab[8]);
    end
    hold(3, 8'hFF, 7'h7F);
    check("t3_digits", 32'(digits), 32'h4321);
    check("t3_err_pattern", 32'(p_ep), 32'd0);
    check("t3_err_anode", 32'(p_ea), 32'd0);

    $display("[TB] two anodes low");
    p_fd = 0; p_ep = 0; p_ea = 0;
    hold(5, 8'hFC, pat_tab[0]);
    hold(2, 8'hFF, 7'h7F);
    check("t4_err_anode_pulses", 32'(p_ea), 32'd1);
    check("t4_digits", 32'(digits), 32'h4321);

    $display("[TB] hex pattern on anode 1");
    p_fd = 0; p_ep = 0; p_ea = 0;
    hold(20, 8'hFD, 7'b0001000);
`ifdef SEG7_HEX_DECODE_EN
    check("t5_digit1", 32'(digits[7:4]), 32'hA);
    check("t5_err_pattern", 32'(p_ep), 32'd0);
`else
    check("t5_digit1", 32'(digits[7:4]), 32'h2);
    check("t5_err_pattern", 32'(p_ep), 32'd1);
`endif

    $display("[TB] reset during settle");
    hold(11, 8'hFB, pat_tab[5]);
    tick(8'hFB, pat_tab[5], 1'b1, 1'b1);
    check("t6_digits", 32'(digits), 32'h0);
    check("t6_valid", 32'(digit_valid), 32'h0);

    $display("[TB] enable dropped during settle");
    hold(10, 8'hF7, pat_tab[9]);
    for (int i = 0; i < 3; i++) tick(8'hF7, pat_tab[9], 1'b0, 1'b0);
    check("en_no_capture", 32'(digit_valid), 32'h0);
    hold(20, 8'hF7, pat_tab[9]);
    check("en_digit3", 32'(digits[15:12]), 32'h9);
    check("en_valid", 32'(digit_valid), 32'h8);

    $display("[TB] random bus traffic");
    for (int t = 0; t < 60; t++) begin
      kind = int'($urandom_range(0, 9));
      ra   = 8'hFF;
      if (kind == 1) begin
        b1 = int'($urandom_range(0, 7));
        b2 = (b1 + 1 + int'($urandom_range(0, 6))) % 8;
        ra[b1] = 1'b0;
        ra[b2] = 1'b0;
      end else if (kind == 2) begin
        ra[$urandom_range(4, 7)] = 1'b0;
      end else if (kind != 0) begin
        ra[$urandom_range(0, 3)] = 1'b0;
      end
      hl = int'($urandom_range(1, 24));
      if ($urandom_range(0, 4) == 0) hold(hl, ra, 7'($urandom_range(0, 127)));
      else hold(hl, ra, pat_tab[$urandom_range(0, 15)]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
